exec_ctrl: RTL and testbench
============================

// Module: exec_ctrl
// PURPOSE
// - Fetch/decode/execute sequencer directly upstream of the 5-bit ALU in the 15-puzzle core.
// - Fetches 16-bit instructions from instruction memory and reads operands from an 8x5-bit register file.
// - Drives alu_op/alu_ina/alu_inb, writes alu_out back to the register file and latches alu_zf for conditional jumps.
// PARAMETERS
// - PC_W     8   instruction address width; PC wraps modulo 2**PC_W
// - NREG     8   register-file depth; rd/rs/rt fields are 3 bits
// - DATA_W   5   datapath width; matches the ALU operands
// PORTS
// - clk         in   1       system clock; all state updates on the rising edge
// - rst         in   1       synchronous, active-high reset
// - run         in   1       start/continue execution; sampled in IDLE
// - imem_addr   out  PC_W    instruction fetch address (= PC)
// - imem_req    out  1       fetch request; held high until imem_valid
// - imem_valid  in   1       imem_rdata valid this cycle; ignored unless imem_req
// - imem_rdata  in   16      instruction {op[15:11], rd[10:8], rs[7:5], rt_imm[4:0]}
// - alu_op      out  5       ALU opcode (def.h encodings)
// - alu_ina     out  DATA_W  ALU operand A = R[rs], or imm for LI
// - alu_inb     out  DATA_W  ALU operand B = R[rt_imm[2:0]]
// - alu_out     in   DATA_W  ALU result (combinational)
// - alu_zf      in   1       ALU zero/compare flag (combinational)
// - zflag       out  1       latched compare flag
// - halted      out  1       high while in HALT state
// BEHAVIOUR
// - Reset: state=IDLE, PC=0, all registers=0, zflag=0, imem_req=0, alu_op=0, alu_ina=0, alu_inb=0, halted=0.
// - FSM: IDLE -> FETCH (run=1) -> DECODE -> EXEC -> WB -> FETCH; HALT is terminal until rst.
// - FETCH: imem_req=1, imem_addr=PC; wait any number of cycles; on imem_valid capture IR, go DECODE.
// - DECODE: register-file read of rs/rt into operand registers; ALU outputs are registered and valid in EXEC.
// - EXEC: ALU outputs stable for the whole cycle; alu_out/alu_zf sampled at the end of EXEC.
// - WB: write-class ops (AND,OR,XOR,ADD,SUB,INC,DEC,LI,COPY,RL,CARD,RCOP*,RL[ID]*,REDST30) write alu_out to R[rd].
// - Compare-class ops (COMP,CHECK,LESS,MORE,AMARIN0,AMARI1,CHECK30) load zflag<=alu_zf; no register write.
// - Other ops leave zflag unchanged; only compare-class ops update it.
// - JZ and HALT encodings come from def.h and are never presented to the ALU (alu_op=0 in EXEC).
// - JZ: in WB, PC<=zflag ? {PC_W-5 zeros, rt_imm} : PC+1. HALT: enter HALT, halted=1, PC frozen.
// - All other ops: PC<=PC+1 in WB; PC=2**PC_W-1 wraps to 0.
// - Unknown op: treated as NOP (no write, zflag held, PC+1).
// - Latency: 4 cycles per instruction with zero-wait imem (FETCH,DECODE,EXEC,WB).
// - run=0 is ignored outside IDLE; run only starts execution.
// - rst mid-FETCH drops imem_req on the next edge; a late imem_valid is ignored.
// - Arithmetic is DATA_W wide and wraps; exec_ctrl adds no saturation.
// - rd==rs is legal: the operand is read in DECODE, written in WB, so the old value is used.
// CONFIGURATION
// - SINGLE_STEP_EN defined: adds input step (1 bit); WB->FETCH only on a cycle with step=1, else stays in WB.
// - In SINGLE_STEP_EN builds the WB write and PC update occur exactly once, on entering WB.
// - SINGLE_STEP_EN undefined: no step port; WB->FETCH unconditional.
// TESTING
// - Reset then run=1, imem zero-wait, LI r1,#7 -> imem_addr 0 in FETCH; R1=7 after 4 cycles; PC=1.
// - LI r1,#7; LI r2,#7; COMP r1,r2; JZ #0x10 -> zflag=1; imem_addr=0x10 on next FETCH.
// - LI r1,#3; LI r2,#5; COMP r1,r2; JZ #0x10 -> zflag=0; PC=4; registers unchanged.
// - imem_valid delayed 3 cycles -> imem_req and imem_addr held stable throughout; IR captured once.
// - ADD r3,r1,r1 with R1=20 -> R3=8 (5-bit wrap); PC=2**PC_W-1 then NOP -> PC=0.
// - HALT -> halted=1, imem_req=0 forever; rst=1 mid-FETCH -> next cycle IDLE, PC=0, registers=0.

Source files
------------

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - fetch/decode/execute sequencer feeding the 5-bit puzzle ALU
// Optional build macro SINGLE_STEP_EN adds a step input that gates WB->FETCH.
module exec_ctrl #(
  parameter int PC_W   = 8,
  parameter int NREG   = 8,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_ina,
  output logic [DATA_W-1:0] alu_inb,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zf,
  output logic              zflag,
  output logic              halted
);

  // Opcode map: 1..16 write-class (AND..REDST30), 17..23 compare-class
  // (COMP..CHECK30), 24 JZ, 25 HALT; 0 and 26..31 behave as NOP.
  localparam logic [4:0] OP_AND     = 5'd1;
  localparam logic [4:0] OP_LI      = 5'd8;
  localparam logic [4:0] OP_REDST30 = 5'd16;
  localparam logic [4:0] OP_COMP    = 5'd17;
  localparam logic [4:0] OP_CHECK30 = 5'd23;
  localparam logic [4:0] OP_JZ      = 5'd24;
  localparam logic [4:0] OP_HALT    = 5'd25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PC_W-1:0]    r_pc;
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_regs [NREG];
  logic               r_zflag;
  logic [4:0]         r_alu_op;
  logic [DATA_W-1:0]  r_alu_ina;
  logic [DATA_W-1:0]  r_alu_inb;

  logic [4:0]         w_op;
  logic [2:0]         w_rd;
  logic [2:0]         w_rs;
  logic [2:0]         w_rt;
  logic [4:0]         w_imm;
  logic               w_is_write;
  logic               w_is_cmp;
  logic [PC_W-1:0]    w_pc_next;

  assign w_op  = r_ir[15:11];
  assign w_rd  = r_ir[10:8];
  assign w_rs  = r_ir[7:5];
  assign w_imm = r_ir[4:0];
  assign w_rt  = r_ir[2:0];

  assign w_is_write = (w_op >= OP_AND)  && (w_op <= OP_REDST30);
  assign w_is_cmp   = (w_op >= OP_COMP) && (w_op <= OP_CHECK30);
  assign w_pc_next  = ((w_op == OP_JZ) && r_zflag) ? PC_W'(w_imm) : r_pc + PC_W'(1);

  assign imem_addr = r_pc;
  assign alu_op    = r_alu_op;
  assign alu_ina   = r_alu_ina;
  assign alu_inb   = r_alu_inb;
  assign zflag     = r_zflag;

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (w_op == OP_HALT) ? S_HALT : S_WB;
`ifdef SINGLE_STEP_EN
      S_WB:     if (step) w_next = S_FETCH;
`else
      S_WB:     w_next = S_FETCH;
`endif
      S_HALT:   halted = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

  // Architectural updates happen on the EXEC->WB edge so that a WB stall
  // (single-step builds) can never repeat the write or the PC step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_zflag   <= 1'b0;
      r_alu_op  <= '0;
      r_alu_ina <= '0;
      r_alu_inb <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && imem_valid) r_ir <= imem_rdata;
      if (r_state == S_DECODE) begin
        r_alu_op  <= (w_is_write || w_is_cmp) ? w_op : 5'd0;
        r_alu_ina <= (w_op == OP_LI) ? DATA_W'(w_imm) : r_regs[w_rs];
        r_alu_inb <= r_regs[w_rt];
      end
      if (r_state == S_EXEC) begin
        if (w_is_write) r_regs[w_rd] <= alu_out;
        if (w_is_cmp) r_zflag <= alu_zf;
        if (w_op != OP_HALT) r_pc <= w_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - instruction-level model bench for exec_ctrl
module tb_exec_ctrl;

  localparam logic [4:0] OPC_ADD  = 5'd4;
  localparam logic [4:0] OPC_SUB  = 5'd5;
  localparam logic [4:0] OPC_LI   = 5'd8;
  localparam logic [4:0] OPC_COPY = 5'd9;
  localparam logic [4:0] OPC_COMP = 5'd17;
  localparam logic [4:0] OPC_MORE = 5'd20;
  localparam logic [4:0] OPC_JZ   = 5'd24;
  localparam logic [4:0] OPC_HALT = 5'd25;
  localparam logic [4:0] OPC_BAD  = 5'd31;

  logic        clk = 1'b0;
  logic        rst, run, imem_valid;
  logic [15:0] imem_rdata;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [4:0]  alu_op, alu_ina, alu_inb, alu_out;
  logic        alu_zf, zflag, halted;

  always #5 clk = ~clk;

  exec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .alu_op     (alu_op),
    .alu_ina    (alu_ina),
    .alu_inb    (alu_inb),
    .alu_out    (alu_out),
    .alu_zf     (alu_zf),
    .zflag      (zflag),
    .halted     (halted)
  );

  // Reference ALU: returns {zf, result}
  function automatic logic [5:0] alu_f(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [4:0] o;
    logic       z;
    o = a;
    z = 1'b0;
    case (op) inside
      5'd1:        o = a & b;
      5'd2:        o = a | b;
      5'd3:        o = a ^ b;
      5'd4:        o = a + b;
      5'd5:        o = a - b;
      5'd6:        o = a + 5'd1;
      5'd7:        o = a - 5'd1;
      5'd10:       o = {a[3:0], a[4]};
      [5'd11:5'd16]: o = ~a;
      5'd17:       z = (a == b);
      5'd18:       z = (a == 5'd0);
      5'd19:       z = (a < b);
      5'd20:       z = (a > b);
      5'd21:       z = (a != 5'd0);
      5'd22:       z = (a == 5'd1);
      5'd23:       z = (a == 5'd30);
      default:     o = a;
    endcase
    return {z, o};
  endfunction

  always_comb {alu_zf, alu_out} = alu_f(alu_op, alu_ina, alu_inb);

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] imm);
    return {op, rd, rs, imm};
  endfunction

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic [4:0] m_r [8];
  logic       m_zf;
  logic       cmp_en;
  logic       e_req, e_halt, e_zf, e_alu;
  logic [7:0] e_addr;
  logic [4:0] e_op, e_ina, e_inb;
  logic [4:0] last_ina;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", 32'(imem_addr), 32'(e_addr));
      chk("halted", 32'(halted), 32'(e_halt));
      chk("zflag", 32'(zflag), 32'(e_zf));
      if (e_alu) begin
        chk("alu_op", 32'(alu_op), 32'(e_op));
        chk("alu_ina", 32'(alu_ina), 32'(e_ina));
        chk("alu_inb", 32'(alu_inb), 32'(e_inb));
      end
    end
  end

  task automatic model_reset();
    m_pc = 8'd0;
    m_zf = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 5'd0;
    e_req = 1'b0; e_halt = 1'b0; e_zf = 1'b0; e_addr = 8'd0;
    e_alu = 1'b1; e_op = 5'd0; e_ina = 5'd0; e_inb = 5'd0;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    e_alu = 1'b0; e_req = 1'b1; e_addr = m_pc;
  endtask

  // Called one step after the edge that entered FETCH; returns likewise at the
  // next FETCH (or in HALT).
  task automatic do_instr(input logic [15:0] ir, input int wt);
    logic [4:0] op, imm, a, b;
    logic [2:0] rd, rs;
    logic [5:0] res;
    op = ir[15:11]; rd = ir[10:8]; rs = ir[7:5]; imm = ir[4:0];
    e_req = 1'b1; e_addr = m_pc; e_alu = 1'b0;
    for (int i = 0; i < wt; i++) begin
      imem_valid = 1'b0; imem_rdata = ~ir;
      @(posedge clk); #1;
    end
    imem_valid = 1'b1; imem_rdata = ir;
    @(posedge clk); #1;
    imem_valid = 1'b0; imem_rdata = ~ir;
    e_req = 1'b0;
    @(posedge clk); #1;
    a = (op == OPC_LI) ? imm : m_r[rs];
    b = m_r[imm[2:0]];
    e_op = (op >= 5'd1 && op <= 5'd23) ? op : 5'd0;
    e_ina = a; e_inb = b; e_alu = 1'b1;
    last_ina = alu_ina;
    @(posedge clk); #1;
    e_alu = 1'b0;
    res = alu_f(e_op, a, b);
    if (op >= 5'd1 && op <= 5'd16) m_r[rd] = res[4:0];
    if (op >= 5'd17 && op <= 5'd23) m_zf = res[5];
    e_zf = m_zf;
    if (op == OPC_HALT) begin
      e_halt = 1'b1;
    end else begin
      m_pc = (op == OPC_JZ && m_zf) ? {3'b000, imm} : m_pc + 8'd1;
      @(posedge clk); #1;
      e_req = 1'b1; e_addr = m_pc;
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int guard;
    rst = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0;
    cmp_en = 1'b0; last_ina = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    start_run();
    chk("first_fetch_addr", 32'(imem_addr), 32'd0);

    do_instr(mk(OPC_LI, 3'd1, 3'd0, 5'd7), 0);
    chk("pc_after_li", 32'(imem_addr), 32'd1);
    chk("model_r1", 32'(m_r[1]), 32'd7);
    do_instr(mk(OPC_LI, 3'd2, 3'd0, 5'd7), 0);
    do_instr(mk(OPC_COMP, 3'd0, 3'd1, 5'd2), 0);
    chk("comp_eq_ina", 32'(last_ina), 32'd7);
    do_instr(mk(OPC_JZ, 3'd0, 3'd0, 5'h10), 0);
    chk("jz_taken_zflag", 32'(zflag), 32'd1);
    chk("jz_taken_addr", 32'(imem_addr), 32'h10);

    do_instr(mk(OPC_LI, 3'd1, 3'd0, 5'd3), 0);
    do_instr(mk(OPC_LI, 3'd2, 3'd0, 5'd5), 0);
    do_instr(mk(OPC_COMP, 3'd0, 3'd1, 5'd2), 0);
    do_instr(mk(OPC_JZ, 3'd0, 3'd0, 5'h10), 0);
    chk("jz_not_taken_zflag", 32'(zflag), 32'd0);
    chk("jz_not_taken_addr", 32'(imem_addr), 32'h14);

    do_instr(mk(OPC_LI, 3'd1, 3'd0, 5'd20), 3);
    do_instr(mk(OPC_ADD, 3'd3, 3'd1, 5'd1), 0);
    do_instr(mk(OPC_COPY, 3'd4, 3'd3, 5'd0), 0);
    chk("add_wrap_r3", 32'(last_ina), 32'd8);
    do_instr(mk(OPC_ADD, 3'd1, 3'd1, 5'd1), 0);
    chk("rd_eq_rs_old", 32'(last_ina), 32'd20);
    do_instr(mk(OPC_COPY, 3'd5, 3'd1, 5'd0), 0);
    chk("rd_eq_rs_new", 32'(last_ina), 32'd8);
    do_instr(mk(OPC_SUB, 3'd6, 3'd0, 5'd2), 0);
    do_instr(mk(OPC_COPY, 3'd7, 3'd6, 5'd0), 0);
    chk("sub_wrap", 32'(last_ina), 32'd27);
    do_instr(mk(OPC_MORE, 3'd0, 3'd1, 5'd2), 0);
    do_instr(mk(5'd0, 3'd7, 3'd1, 5'd1), 0);
    do_instr(mk(OPC_BAD, 3'd7, 3'd1, 5'd1), 0);
    chk("nop_holds_zflag", 32'(zflag), 32'd1);
    do_instr(mk(OPC_JZ, 3'd0, 3'd0, 5'd5), 0);
    chk("jz_after_nops", 32'(imem_addr), 32'd5);

    guard = 0;
    while (m_pc != 8'hFF && guard < 300) begin
      do_instr(mk(OPC_BAD, 3'd7, 3'd1, 5'd1), 0);
      guard++;
    end
    chk("pc_top", 32'(imem_addr), 32'hFF);
    do_instr(mk(5'd0, 3'd7, 3'd2, 5'd2), 0);
    chk("pc_wrap", 32'(imem_addr), 32'd0);
    do_instr(mk(OPC_COPY, 3'd0, 3'd7, 5'd0), 0);
    chk("nop_no_write", 32'(last_ina), 32'd27);

    do_instr(mk(OPC_HALT, 3'd0, 3'd0, 5'd0), 0);
    for (int i = 0; i < 8; i++) begin
      run = i[0];
      @(posedge clk); #1;
    end
    run = 1'b0;
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(imem_req), 32'd0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    start_run();
    imem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_drops_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b1; imem_rdata = mk(OPC_LI, 3'd1, 3'd0, 5'd9);
    repeat (2) @(posedge clk);
    #1 imem_valid = 1'b0;
    chk("late_valid_ignored", 32'(imem_req), 32'd0);
    start_run();
    chk("restart_addr", 32'(imem_addr), 32'd0);
    do_instr(mk(OPC_COPY, 3'd2, 3'd1, 5'd0), 0);
    chk("regs_cleared", 32'(last_ina), 32'd0);
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
